button_cmd_encoder: RTL and testbench

//  Front end that produces the 8-bit command byte consumed by the stats block. Synchronizes
//  and debounces six raw push-buttons, priority-encodes them into ASCII command codes and

---
 rtl/button_cmd_encoder.sv | 122 ++++++++++++
 tb/tb_button_cmd_encoder.sv | 135 +++++++++++++
 2 files changed

// File: rtl/button_cmd_encoder.sv
// Button front end: synchronizes and debounces six push-buttons, priority-encodes them
// to ASCII command bytes and emits one fixed-width command pulse per debounced press.
module button_cmd_encoder #(
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int HOLD_CYCLES     = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] btn,
    input  logic       asleep,
    output logic [7:0] cmd,
    output logic       cmd_valid,
    output logic       busy
);

    localparam int MAX_COUNT = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int CW        = $clog2(MAX_COUNT + 1);

    localparam logic [CW-1:0] DEB_MAX  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] ONE      = CW'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUAL    = 2'd1,
        EMIT    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t        state_reg;
    logic [5:0]    sync_reg;
    logic [5:0]    s_reg;
    logic [7:0]    cand_reg;
    logic [7:0]    cmd_reg;
    logic          valid_reg;
    logic [CW-1:0] cnt_reg;

    logic [5:0]    masked;
    logic [7:0]    code;

    // While asleep only the wake button may produce a command.
    assign masked = asleep ? (s_reg & 6'b10_0000) : s_reg;

    always_comb begin
        code = 8'h00;
        if      (masked[5]) code = 8'h77;
        else if (masked[4]) code = 8'h73;
        else if (masked[3]) code = 8'h62;
        else if (masked[2]) code = 8'h64;
        else if (masked[1]) code = 8'h70;
        else if (masked[0]) code = 8'h65;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
            sync_reg  <= 6'd0;
            s_reg     <= 6'd0;
            cand_reg  <= 8'h00;
            cmd_reg   <= 8'h00;
            valid_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync_reg <= btn;
            s_reg    <= sync_reg;
            case (state_reg)
                IDLE: begin
                    if (code != 8'h00) begin
                        cand_reg  <= code;
                        cnt_reg   <= ONE;
                        state_reg <= QUAL;
                    end
                end
                QUAL: begin
                    if (code != cand_reg) begin
                        cnt_reg   <= '0;
                        state_reg <= IDLE;
                    end else if (cnt_reg == DEB_MAX) begin
                        cmd_reg   <= cand_reg;
                        valid_reg <= 1'b1;
                        cnt_reg   <= ONE;
                        state_reg <= EMIT;
                    end else begin
                        cnt_reg <= cnt_reg + ONE;
                    end
                end
                EMIT: begin
                    // Pulse width is fixed; buttons and asleep are ignored here.
                    if (cnt_reg == HOLD_MAX) begin
                        cmd_reg   <= 8'h00;
                        valid_reg <= 1'b0;
                        cnt_reg   <= '0;
                        state_reg <= RELEASE;
                    end else begin
                        cnt_reg <= cnt_reg + ONE;
                    end
                end
                RELEASE: begin
                    // Any activity restarts the all-released debounce window.
                    if (s_reg != 6'd0) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DEB_LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + ONE;
                    end
                end
                default: begin
                    cnt_reg   <= '0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign cmd       = cmd_reg;
    assign cmd_valid = valid_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_button_cmd_encoder.sv
// Directed bench for button_cmd_encoder with DEBOUNCE_CYCLES=4, HOLD_CYCLES=3.
module tb_button_cmd_encoder;

    localparam int D = 4;
    localparam int H = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] btn;
    logic       asleep;
    logic [7:0] cmd;
    logic       cmd_valid;
    logic       busy;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int base;

    button_cmd_encoder #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn       (btn),
        .asleep    (asleep),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // Runs n cycles; a press applied just after edge b must show code on edges b+3+D .. b+2+D+H.
    task automatic window(input string tag, input int n, input int b, input logic [7:0] code);
        logic [7:0] exp;
        for (int i = 0; i < n; i++) begin
            tick();
            exp = (cyc >= b + 3 + D && cyc <= b + 2 + D + H) ? code : 8'h00;
            chk(tag, cmd, exp);
            chk({tag, "_valid"}, {7'd0, cmd_valid}, {7'd0, exp != 8'h00});
        end
        $display("txn %s: %0d cycles from edge %0d, code %h", tag, n, b, code);
    endtask

    initial begin
        reset  = 1'b0;
        btn    = 6'h3F;
        asleep = 1'b0;

        // 1: outputs stay quiet while reset is held
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_cmd", cmd, 8'h00);
            chk("rst_valid", {7'd0, cmd_valid}, 8'h00);
            chk("rst_busy", {7'd0, busy}, 8'h00);
        end
        btn = 6'h00;
        tick();
        reset = 1'b1;
        window("idle", 5, cyc, 8'h00);

        // 2: single feed press, held long, one pulse only
        base = cyc;
        btn  = 6'h01;
        window("feed", 40, base, 8'h65);
        btn = 6'h00;
        window("feed_rel", 12, -100, 8'h00);
        chk("feed_busy", {7'd0, busy}, 8'h00);

        // 3: play+feed together -> play only; then feed after release
        base = cyc;
        btn  = 6'h03;
        window("play", 20, base, 8'h70);
        btn = 6'h00;
        window("play_rel", 10, -100, 8'h00);
        chk("play_busy", {7'd0, busy}, 8'h00);
        base = cyc;
        btn  = 6'h01;
        window("feed2", 15, base, 8'h65);
        btn = 6'h00;
        window("feed2_rel", 10, -100, 8'h00);

        // 4: short glitch never emits
        btn = 6'h01;
        tick(); tick(); tick();
        chk("glitch_busy_hi", {7'd0, busy}, 8'h01);
        btn = 6'h00;
        window("glitch", 10, -100, 8'h00);
        chk("glitch_busy_lo", {7'd0, busy}, 8'h00);

        // 5: asleep masks play, wake still works
        asleep = 1'b1;
        btn    = 6'h02;
        window("sleep_play", 20, -100, 8'h00);
        chk("sleep_busy", {7'd0, busy}, 8'h00);
        base = cyc;
        btn  = 6'h20;
        window("wake", 15, base, 8'h77);
        btn = 6'h00;
        window("wake_rel", 10, -100, 8'h00);
        asleep = 1'b0;

        // 6: reset during second EMIT cycle, then fresh pulse with button still held
        base = cyc;
        btn  = 6'h10;
        window("sleep_cmd", 7, base, 8'h73);
        reset = 1'b0;
        tick();
        chk("midrst_cmd", cmd, 8'h00);
        chk("midrst_valid", {7'd0, cmd_valid}, 8'h00);
        chk("midrst_busy", {7'd0, busy}, 8'h00);
        reset = 1'b1;
        base  = cyc;
        window("sleep_cmd2", 15, base, 8'h73);
        btn = 6'h00;
        window("sleep_rel", 10, -100, 8'h00);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
